// File: rtl/seq_cmp_if.sv
// Handshake and operand/result bundle for the multi-cycle magnitude comparator.
interface seq_cmp_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             is_signed;
  logic             busy;
  logic             done;
  logic             eq;
  logic             lt;
  logic             gt;

  modport master (
    output start, x, y, is_signed,
    input  busy, done, eq, lt, gt
  );

  modport slave (
    input  start, x, y, is_signed,
    output busy, done, eq, lt, gt
  );
endinterface

// File: rtl/seq_cmp.sv
// Multi-cycle magnitude comparator: walks CHUNK-bit slices MSB-first, one per clock,
// and stops at the first differing slice. Supports unsigned and two's-complement modes.
module seq_cmp #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_cmp_if.slave bus
);
  localparam int NSLICE = WIDTH / CHUNK;
  localparam int IW     = $clog2(NSLICE) + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CMP  = 1'b1;

  logic [0:0]       state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic             sgn_q;
  logic             done_q;
  logic             eq_q;
  logic             lt_q;
  logic             gt_q;

  logic [WIDTH-1:0] x_k;
  logic [WIDTH-1:0] y_k;
  logic [CHUNK-1:0] x_s;
  logic [CHUNK-1:0] y_s;
  logic             last;

  // The MSB lives only in slice 0, so flipping it unconditionally in signed mode
  // biases the top slice and leaves every other slice an unsigned compare.
  always_comb begin
    x_k = {x_q[WIDTH-1] ^ sgn_q, x_q[WIDTH-2:0]};
    y_k = {y_q[WIDTH-1] ^ sgn_q, y_q[WIDTH-2:0]};
    x_s = '0;
    y_s = '0;
    for (int unsigned i = 0; i < NSLICE; i++) begin
      if (idx == IW'(i)) begin
        x_s = x_k[WIDTH-1-i*CHUNK -: CHUNK];
        y_s = y_k[WIDTH-1-i*CHUNK -: CHUNK];
      end
    end
    last = (idx == IW'(NSLICE - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      x_q    <= '0;
      y_q    <= '0;
      sgn_q  <= 1'b0;
      done_q <= 1'b0;
      eq_q   <= 1'b0;
      lt_q   <= 1'b0;
      gt_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= CMP;
            idx   <= '0;
            x_q   <= bus.x;
            y_q   <= bus.y;
            sgn_q <= bus.is_signed;
          end
        end
        CMP: begin
          if (x_s != y_s) begin
            gt_q   <= (x_s > y_s);
            lt_q   <= (x_s < y_s);
            eq_q   <= 1'b0;
            done_q <= 1'b1;
            state  <= IDLE;
          end else if (last) begin
            gt_q   <= 1'b0;
            lt_q   <= 1'b0;
            eq_q   <= 1'b1;
            done_q <= 1'b1;
            state  <= IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state == CMP);
  assign bus.done = done_q;
  assign bus.eq   = eq_q;
  assign bus.lt   = lt_q;
  assign bus.gt   = gt_q;
endmodule
